clm_subbytes: RTL and testbench
===============================

# clm_subbytes

Sequencer for the masked SubBytes step. It takes a 16-byte code-masked AES state and feeds one (8+d)-bit codeword at a time into the single `clm_sbox` instance. For each byte it supplies fresh randomness, captures the substituted codeword when the S-box reports `drdy_o`, and assembles the result. It sits between the round-state register and `clm_sbox`: upstream it drives the S-box `in`/`r`/`drdy_i`, and downstream it consumes `out`/`drdy_o`.

## Interface
- `d`, default 8: redundancy width. Codeword width W = 8+d, the same as `state_t`.
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `start`  in  1  single-cycle request. Sampled only in IDLE.
- `state_in`  in  16*W  masked state. Byte i occupies bits [i*W +: W].
- `rand_in`  in  5*W  fresh randomness, slot k = bits [k*W +: W].
- `rand_ack`  out  1  high in the cycle `rand_in` is sampled. The source must present a new value from the next cycle.
- `sbox_in`  out  W  registered codeword to the S-box `in`.
- `sbox_r`  out  5*W  registered randomness to the S-box `r[0..4]`.
- `sbox_drdy_i`  out  1  S-box start.
- `sbox_out`  in  W  S-box result.
- `sbox_drdy_o`  in  1  S-box result valid. Combinational from the S-box, high for one cycle.
- `state_out`  out  16*W  substituted state. Held until the next accepted `start` or reset.
- `busy`  out  1  high in ISSUE and WAIT.
- `done`  out  1  single-cycle completion pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. There is a 4-bit byte index `idx`.
- IDLE, with `start`=1:
  - latch `state_in` into the internal copy;
  - set `idx`=0;
  - load `sbox_in` ← byte 0 and `sbox_r` ← `rand_in`;
  - assert `rand_ack`;
  - clear `state_out` to 0;
  - go to ISSUE.
- ISSUE: `sbox_drdy_i`=1 for exactly this cycle, then go to WAIT.
- WAIT, with `sbox_drdy_o`=1:
  - write `state_out[idx]` ← `sbox_out`;
  - if `idx`=15, go to DONE;
  - otherwise increment `idx`, load `sbox_in` ← byte `idx`+1 and `sbox_r` ← `rand_in`, assert `rand_ack`, and go to ISSUE.
- DONE: `done`=1, then go to IDLE.
- `sbox_in` and `sbox_r` are stable from ISSUE through the `sbox_drdy_o` cycle. This is mandatory: the S-box re-reads `in` and `r[1..4]` in later stages. They change only at the load events listed above.
- `sbox_drdy_o` outside WAIT is ignored, with no state change.
- `start` outside IDLE is ignored. That includes DONE and the `start` cycle itself; no queueing.
- There is no arithmetic on codewords. The block routes data only. `idx` never wraps, because termination happens at 15.
- Reset mid-operation:
  - next state is IDLE;
  - all outputs return to their reset values;
  - the partial `state_out` is discarded.
  - The S-box shares `rst` and returns to its first stage, so no stale `drdy_o` is expected.

## Timing
- Reset values: `rand_ack`=0, `sbox_in`=0, `sbox_r`=0, `sbox_drdy_i`=0, `state_out`=0, `busy`=0, `done`=0; FSM state IDLE; `idx`=0.
- Start accepted in cycle T. Byte i, against the nominal 7-cycle S-box:
  - ISSUE at T+1+7i;
  - `sbox_drdy_o` at T+7+7i;
  - 7 cycles per byte.
- Last capture is at T+112. `done` is high at T+113. `state_out` is final from T+113.
- `busy` is high T+1..T+112. The earliest next accepted `start` is T+114.
- The byte period adapts to any S-box latency ≥1, because progression is gated only by `sbox_drdy_o`.
- `rand_ack` pulses exactly 16 times per run: at T, then at T+7+7i for i=0..14.

## Test plan
- Reset check: assert `rst` for 3 cycles with `start`=1. All outputs are 0, `busy`=0, and no `sbox_drdy_i` pulse occurs.
- Full run against a 7-stage behavioural S-box stub (out = ~in), with W=16 and byte i = 16'h0100*i+i:
  - `state_out` byte i = ~(16'h0100*i+i);
  - `done` pulses once, at T+113.
- Randomness, with `rand_in` incremented every cycle and the real `clm_sbox` compared to the golden masked model:
  - 16 `rand_ack` pulses at the specified cycles;
  - `sbox_r` equals the `rand_in` value from the `rand_ack` cycle;
  - `sbox_in`/`sbox_r` are unchanged from ISSUE until `sbox_drdy_o`.
- Busy interlock: pulse `start` at T+1, T+50 and T+113 with a different `state_in`. Only the first run executes, `state_out` reflects the original state, and `done` occurs once.
- Mid-run reset: assert `rst` one cycle at T+55, with byte 7 in flight. The next cycle has all outputs 0 and the state is IDLE. A new `start` then completes a correct full run in 113 cycles.
- Variable latency: the stub delays `sbox_drdy_o` 3..12 cycles randomly per byte, and stray `sbox_drdy_o` pulses are injected in IDLE. The result is still correct, strays are ignored, and `done` follows the last capture by 1 cycle.

Source files
------------

// File: rtl/clm_subbytes.sv
// clm_subbytes: sequences 16 masked codewords through one clm_sbox and reassembles the substituted state
module clm_subbytes #(
  parameter int d = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [16*(8+d)-1:0]   state_in,
  input  logic [5*(8+d)-1:0]    rand_in,
  output logic                  rand_ack,
  output logic [8+d-1:0]        sbox_in,
  output logic [5*(8+d)-1:0]    sbox_r,
  output logic                  sbox_drdy_i,
  input  logic [8+d-1:0]        sbox_out,
  input  logic                  sbox_drdy_o,
  output logic [16*(8+d)-1:0]   state_out,
  output logic                  busy,
  output logic                  done
);
  localparam int W = 8 + d;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} fsm_e;
  fsm_e            fsm_q, fsm_d;
  logic [3:0]      idx_q, idx_d, nxt;
  logic [16*W-1:0] st_q, st_d, out_q, out_d;
  logic [W-1:0]    in_q, in_d;
  logic [5*W-1:0]  r_q, r_d;
  logic            acc, cap, load;
  // next-state: accept in IDLE, issue one byte, wait for the S-box, loop until byte 15 is captured
  always_comb begin
    acc   = !rst && fsm_q == IDLE && start;
    cap   = fsm_q == WAIT && sbox_drdy_o;
    load  = acc || (!rst && cap && idx_q != 4'd15);
    nxt   = idx_q + 4'd1;
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    fsm_d = start ? ISSUE : IDLE;
      ISSUE:   fsm_d = WAIT;
      WAIT:    fsm_d = !sbox_drdy_o ? WAIT : idx_q == 4'd15 ? DONE : ISSUE;
      default: fsm_d = IDLE;
    endcase
    idx_d = acc ? 4'd0 : load ? nxt : idx_q;
    st_d  = acc ? state_in : st_q;
    in_d  = acc ? state_in[W-1:0] : load ? st_q[nxt*W +: W] : in_q;
    r_d   = load ? rand_in : r_q;
    out_d = acc ? '0 : out_q;
    if (cap) out_d[idx_q*W +: W] = sbox_out;
  end
  // state registers; S-box operands only move at load events so they stay stable while a byte is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      idx_q <= '0;
      st_q  <= '0;
      in_q  <= '0;
      r_q   <= '0;
      out_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
      st_q  <= st_d;
      in_q  <= in_d;
      r_q   <= r_d;
      out_q <= out_d;
    end
  end
  assign rand_ack    = load;
  assign sbox_in     = in_q;
  assign sbox_r      = r_q;
  assign sbox_drdy_i = fsm_q == ISSUE;
  assign state_out   = out_q;
  assign busy        = fsm_q == ISSUE || fsm_q == WAIT;
  assign done        = fsm_q == DONE;
endmodule

// File: tb/tb_clm_subbytes.sv
// tb_clm_subbytes: scoreboard bench for clm_subbytes against an inverting S-box stub
module tb_clm_subbytes;
  localparam int W = 16;
  logic            clk = 0, rst, start, stray, var_lat;
  logic [16*W-1:0] state_in, state_out;
  logic [5*W-1:0]  rand_in, sbox_r;
  logic [W-1:0]    sbox_in, sbox_out, stub_val;
  logic            rand_ack, sbox_drdy_i, sbox_drdy_o, stub_drdy, busy, done;
  int cyc = 0, cnt, checks = 0, errs = 0, done_cnt = 0, done_cyc = 0, last_cap = 0;
  int t0, busy_rise = 0, busy_last = 0;
  logic            busy_prev = 0;
  logic [W-1:0]    held_in;
  logic [5*W-1:0]  held_r;
  logic [W-1:0]    in_q[$];
  logic [16*W-1:0] res_q[$];
  logic [5*W-1:0]  rv_q[$];
  int              ack_q[$];

  clm_subbytes #(.d(8)) dut (
    .clk(clk), .rst(rst), .start(start), .state_in(state_in), .rand_in(rand_in),
    .rand_ack(rand_ack), .sbox_in(sbox_in), .sbox_r(sbox_r), .sbox_drdy_i(sbox_drdy_i),
    .sbox_out(sbox_out), .sbox_drdy_o(sbox_drdy_o), .state_out(state_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rand_in = {5{cyc[15:0]}} ^ {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};

  // S-box stub: result ~in, drdy_o D cycles after the issue cycle (D = 6 nominal, or 3..12)
  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
      stub_drdy <= 0;
    end else begin
      stub_drdy <= cnt == 1;
      if (sbox_drdy_i) begin
        cnt <= (var_lat ? int'($urandom_range(12, 3)) : 6) - 1;
        stub_val <= ~sbox_in;
      end else if (cnt > 0) cnt <= cnt - 1;
    end
  end
  assign sbox_out = stub_val;
  assign sbox_drdy_o = stub_drdy | stray;

  // scoreboard monitor
  always @(negedge clk) if (!rst) begin
    if (rand_ack) begin
      ack_q.push_back(cyc);
      rv_q.push_back(rand_in);
    end
    if (sbox_drdy_i) begin
      checks++;
      if (in_q.size() == 0 || sbox_in !== in_q[0]) begin
        errs++;
        $display("FAIL sbox_in cyc %0d got %h exp %h", cyc, sbox_in, in_q.size() ? in_q[0] : 'x);
      end
      if (in_q.size()) void'(in_q.pop_front());
      checks++;
      if (rv_q.size() == 0 || sbox_r !== rv_q[0]) begin
        errs++;
        $display("FAIL sbox_r cyc %0d got %h exp %h", cyc, sbox_r, rv_q.size() ? rv_q[0] : 'x);
      end
      if (rv_q.size()) void'(rv_q.pop_front());
      held_in = sbox_in;
      held_r = sbox_r;
    end else if (busy) begin
      checks++;
      if (sbox_in !== held_in || sbox_r !== held_r) begin
        errs++;
        $display("FAIL operand_stable cyc %0d got %h/%h exp %h/%h", cyc, sbox_in, sbox_r, held_in, held_r);
      end
    end
    if (busy && sbox_drdy_o) last_cap = cyc;
    if (busy && !busy_prev) busy_rise = cyc;
    if (busy) busy_last = cyc;
    busy_prev = busy;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      checks++;
      if (res_q.size() == 0 || state_out !== res_q[0]) begin
        errs++;
        $display("FAIL state_out got %h exp %h", state_out, res_q.size() ? res_q[0] : 'x);
      end
      if (res_q.size()) void'(res_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) tick();
  endtask

  task automatic go(input logic [16*W-1:0] s, input bit accept);
    state_in = s;
    start = 1;
    if (accept) begin
      for (int i = 0; i < 16; i++) in_q.push_back(s[i*W +: W]);
      res_q.push_back(~s);
      t0 = cyc;
    end
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int bound);
    int n = done_cnt;
    int k = 0;
    while (done_cnt == n && k < bound) begin
      tick();
      k++;
    end
    checks++;
    if (done_cnt == n) begin
      errs++;
      $display("FAIL done_timeout got none exp done within %0d cycles", bound);
    end
  endtask

  function automatic logic [16*W-1:0] rnd_state();
    logic [16*W-1:0] s;
    for (int i = 0; i < 16; i++) s[i*W +: W] = W'($urandom);
    return s;
  endfunction

  logic [16*W-1:0] sa, sb, sc;

  task automatic test_reset();
    rst = 1;
    start = 1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rand_ack, sbox_in, sbox_r, sbox_drdy_i, state_out, busy, done} !== '0) begin
        errs++;
        $display("FAIL reset_outputs got ack=%b drdy_i=%b busy=%b done=%b in=%h exp all 0",
                 rand_ack, sbox_drdy_i, busy, done, sbox_in);
      end
    end
    tick();
    rst = 0;
    start = 0;
    tick();
  endtask

  task automatic test_full();
    int dc0 = done_cnt;
    int t;
    for (int i = 0; i < 16; i++) sa[i*W +: W] = 16'(i * 257);
    ack_q.delete();
    var_lat = 0;
    go(sa, 1);
    t = t0;
    wait_done(200);
    checks++;
    if (done_cyc != t + 113) begin
      errs++;
      $display("FAIL done_cycle got %0d exp %0d", done_cyc - t, 113);
    end
    checks++;
    if (busy_rise != t + 1 || busy_last != t + 112) begin
      errs++;
      $display("FAIL busy_window got %0d..%0d exp 1..112", busy_rise - t, busy_last - t);
    end
    checks++;
    if (ack_q.size() != 16) begin
      errs++;
      $display("FAIL rand_ack_count got %0d exp 16", ack_q.size());
    end
    for (int j = 0; j < 16 && j < ack_q.size(); j++) begin
      checks++;
      if (ack_q[j] != t + 7 * j) begin
        errs++;
        $display("FAIL rand_ack_cycle %0d got %0d exp %0d", j, ack_q[j] - t, 7 * j);
      end
    end
    repeat (3) tick();
    checks++;
    if (done_cnt - dc0 != 1 || busy !== 0 || state_out !== ~sa) begin
      errs++;
      $display("FAIL full_hold got dones=%0d busy=%b out=%h exp 1/0/%h", done_cnt - dc0, busy, state_out, ~sa);
    end
  endtask

  task automatic test_interlock();
    int dc0 = done_cnt;
    int t;
    sb = rnd_state();
    go(sa ^ {16{16'h5a5a}}, 1);
    t = t0;
    at_cycle(t + 1);
    go(sb, 0);
    at_cycle(t + 50);
    go(sb, 0);
    at_cycle(t + 113);
    go(sb, 0);
    at_cycle(t + 120);
    checks++;
    if (done_cnt - dc0 != 1) begin
      errs++;
      $display("FAIL interlock_dones got %0d exp 1", done_cnt - dc0);
    end
    checks++;
    if (state_out !== ~(sa ^ {16{16'h5a5a}}) || busy !== 0 || in_q.size() != 0) begin
      errs++;
      $display("FAIL interlock_state got %h busy=%b exp %h busy=0", state_out, busy, ~(sa ^ {16{16'h5a5a}}));
    end
  endtask

  task automatic test_midreset();
    int t;
    go(sa, 1);
    t = t0;
    at_cycle(t + 55);
    rst = 1;
    tick();
    rst = 0;
    in_q.delete();
    rv_q.delete();
    res_q.delete();
    @(negedge clk);
    checks++;
    if ({rand_ack, sbox_in, sbox_r, sbox_drdy_i, state_out, busy, done} !== '0) begin
      errs++;
      $display("FAIL midreset_outputs got ack=%b drdy_i=%b busy=%b done=%b out=%h exp all 0",
               rand_ack, sbox_drdy_i, busy, done, state_out);
    end
    tick();
    sb = rnd_state();
    go(sb, 1);
    t = t0;
    wait_done(200);
    checks++;
    if (done_cyc != t + 113) begin
      errs++;
      $display("FAIL midreset_rerun_done got %0d exp 113", done_cyc - t);
    end
  endtask

  task automatic test_var_latency();
    int dc0 = done_cnt;
    var_lat = 1;
    for (int k = 0; k < 6; k++) begin
      stray = 1;
      tick();
      stray = 0;
      tick();
    end
    checks++;
    if (busy !== 0 || done_cnt != dc0 || state_out !== ~sb) begin
      errs++;
      $display("FAIL stray_ignored got busy=%b dones=%0d out=%h exp 0/0/%h", busy, done_cnt - dc0, state_out, ~sb);
    end
    ack_q.delete();
    sc = rnd_state();
    go(sc, 1);
    wait_done(400);
    checks++;
    if (done_cyc != last_cap + 1) begin
      errs++;
      $display("FAIL var_done_after_cap got %0d exp %0d", done_cyc, last_cap + 1);
    end
    checks++;
    if (ack_q.size() != 16) begin
      errs++;
      $display("FAIL var_rand_ack_count got %0d exp 16", ack_q.size());
    end
    repeat (3) tick();
  endtask

  initial begin
    rst = 1;
    start = 0;
    stray = 0;
    var_lat = 0;
    state_in = '0;
    test_reset();
    test_full();
    test_interlock();
    test_midreset();
    test_var_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
